// File: rtl/l0_pkg.sv
// Shared constants and width helper for the L0 skew buffer.
package l0_pkg;

  localparam logic L0_MODE_PAR  = 1'b0;
  localparam logic L0_MODE_SKEW = 1'b1;

  // Smallest n with 2**n >= value; used for pointer and count widths.
  function automatic int l0_clog2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/l0_row_fifo.sv
// One row of the L0 buffer: circular FIFO with registered head output and valid.
module l0_row_fifo
  import l0_pkg::*;
#(
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [bw-1:0] in,
  output logic [bw-1:0] out,
  output logic          o_valid,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = l0_clog2(depth);
  localparam int CW = AW + 1;

  logic [bw-1:0] mem [depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign push    = wr && !o_full;
  assign pop     = rd && !o_empty;
  assign o_full  = (count == CW'(depth));
  assign o_empty = (count == '0);

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out     <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        out    <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l0_skew_buffer.sv
// L0 input buffer: per-row FIFOs written in parallel, drained in parallel or diagonally staggered.
module l0_skew_buffer
  import l0_pkg::*;
#(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [row*bw-1:0] in,
  input  logic              rd,
  input  logic              mode,
  output logic [row*bw-1:0] out,
  output logic [row-1:0]    o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_empty,
  output logic              o_ovf
);

  logic [row-1:0] rd_en;
  logic [row-1:0] full;
  logic [row-1:0] empty;
  logic           mode_lat;
  logic           eff_mode;
  logic           wr_ok;

  // While enables are in flight the latched mode rules; once idle the live input does.
  assign eff_mode = (rd_en == '0) ? mode : mode_lat;
  // Whole vectors only: a write is refused in every row if any row is full.
  assign wr_ok    = wr && !o_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_en    <= '0;
      mode_lat <= L0_MODE_PAR;
      o_ovf    <= 1'b0;
    end else begin
      if (rd_en == '0) mode_lat <= mode;
      if (eff_mode == L0_MODE_SKEW) rd_en <= {rd_en[row-2:0], rd};
      else                          rd_en <= {row{rd}};
      if (wr && o_full) o_ovf <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < row; gi++) begin : g_row
    l0_row_fifo #(
      .bw    (bw),
      .depth (depth)
    ) u_row (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr_ok),
      .rd      (rd_en[gi]),
      .in      (in[gi*bw +: bw]),
      .out     (out[gi*bw +: bw]),
      .o_valid (o_valid[gi]),
      .o_full  (full[gi]),
      .o_empty (empty[gi])
    );
  end

  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign o_empty = &empty;

endmodule

// File: tb/tb_l0_skew_buffer.sv
// Randomised and directed bench for l0_skew_buffer against a queue/schedule reference model.
module tb_l0_skew_buffer;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 4;
  localparam int W     = ROW * BW;

  logic           clk = 1'b0;
  logic           reset;
  logic           wr;
  logic           rd;
  logic           mode;
  logic [W-1:0]   in_v;
  logic [W-1:0]   out_v;
  logic [ROW-1:0] valid_v;
  logic           full_v, ready_v, empty_v, ovf_v;

  l0_skew_buffer #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (in_v),
    .rd      (rd),
    .mode    (mode),
    .out     (out_v),
    .o_valid (valid_v),
    .o_full  (full_v),
    .o_ready (ready_v),
    .o_empty (empty_v),
    .o_ovf   (ovf_v)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-row entry queues plus a time-indexed table of when each row may pop.
  logic [BW-1:0]  q [ROW][$];
  bit             sched [ROW][128];
  int             t;
  bit             m_mode;
  bit             m_ovf;
  logic [W-1:0]   m_out;
  logic [ROW-1:0] m_valid;

  task automatic model_reset();
    for (int i = 0; i < ROW; i++) begin
      q[i].delete();
      for (int j = 0; j < 128; j++) sched[i][j] = 1'b0;
    end
    m_mode  = 1'b0;
    m_ovf   = 1'b0;
    m_out   = '0;
    m_valid = '0;
  endtask

  task automatic model_edge(input bit w, input logic [W-1:0] d, input bit r, input bit m);
    bit en [ROW];
    bit busy;
    bit eff;
    bit full;
    busy = 1'b0;
    full = 1'b0;
    for (int i = 0; i < ROW; i++) begin
      en[i] = sched[i][t % 128];
      sched[i][t % 128] = 1'b0;
      busy |= en[i];
      if (q[i].size() == DEPTH) full = 1'b1;
    end
    eff = busy ? m_mode : m;
    if (!busy) m_mode = m;
    // rd at this edge lets row i pop one edge later, plus i more edges when staggered.
    if (r) for (int i = 0; i < ROW; i++) sched[i][(t + 1 + (eff ? i : 0)) % 128] = 1'b1;
    m_valid = '0;
    for (int i = 0; i < ROW; i++) begin
      if (en[i] && q[i].size() > 0) begin
        m_out[i*BW +: BW] = q[i].pop_front();
        m_valid[i] = 1'b1;
      end
    end
    if (w) begin
      if (full) m_ovf = 1'b1;
      else for (int i = 0; i < ROW; i++) q[i].push_back(d[i*BW +: BW]);
    end
    t++;
  endtask

  task automatic compare(input string tag);
    bit any_full;
    bit all_empty;
    any_full  = 1'b0;
    all_empty = 1'b1;
    for (int i = 0; i < ROW; i++) begin
      if (q[i].size() == DEPTH) any_full = 1'b1;
      if (q[i].size() != 0) all_empty = 1'b0;
    end
    check({tag, ".out"},   64'(out_v),   64'(m_out));
    check({tag, ".valid"}, 64'(valid_v), 64'(m_valid));
    check({tag, ".full"},  64'(full_v),  64'(any_full));
    check({tag, ".ready"}, 64'(ready_v), 64'(!any_full));
    check({tag, ".empty"}, 64'(empty_v), 64'(all_empty));
    check({tag, ".ovf"},   64'(ovf_v),   64'(m_ovf));
  endtask

  task automatic step(input string tag, input bit w, input logic [W-1:0] d, input bit r, input bit m);
    wr   = w;
    in_v = d;
    rd   = r;
    mode = m;
    @(posedge clk);
    model_edge(w, d, r, m);
    #1;
    $display("%s t=%0d wr=%0b in=%h rd=%0b mode=%0b -> out=%h valid=%h full=%0b empty=%0b ovf=%0b",
             tag, t, w, d, r, m, out_v, valid_v, full_v, empty_v, ovf_v);
    compare(tag);
  endtask

  // Reset pulse placed mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 compare("async_rst");
    $display("async_rst t=%0d out=%h valid=%h empty=%0b ready=%0b", t, out_v, valid_v, empty_v, ready_v);
    #1 reset = 1'b0;
  endtask

  logic [W-1:0] vec;
  bit           rmode;

  initial begin
    reset = 1'b1;
    wr = 1'b0; rd = 1'b0; mode = 1'b0; in_v = '0;
    t = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 compare("reset");
    @(negedge clk);
    reset = 1'b0;

    // Parallel read
    step("par", 1'b1, 32'h76543210, 1'b0, 1'b0);
    step("par", 1'b1, 32'hFEDCBA98, 1'b0, 1'b0);
    step("par", 1'b0, '0, 1'b1, 1'b0);
    step("par", 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step("par", 1'b0, '0, 1'b0, 1'b0);
    async_reset();

    // Staggered fill and drain
    for (int k = 0; k < 3; k++) step("skew", 1'b1, W'($urandom), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step("skew", 1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 11; k++) step("skew", 1'b0, '0, 1'b0, 1'b1);
    async_reset();

    // Full and overflow
    for (int k = 0; k < 4; k++) step("full", 1'b1, W'($urandom), 1'b0, 1'b0);
    step("full", 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
    step("full", 1'b0, '0, 1'b0, 1'b0);
    step("full", 1'b1, 32'h55555555, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step("full", 1'b0, '0, 1'b1, 1'b0);
    async_reset();

    // Wrap-around with concurrent push/pop
    for (int k = 0; k < 14; k++) step("wrap", k < 10, W'($urandom), k >= 1, 1'b0);
    async_reset();

    // Mode change while enables are in flight
    for (int k = 0; k < 4; k++) step("mchg", 1'b1, W'($urandom), 1'b0, 1'b1);
    step("mchg", 1'b0, '0, 1'b1, 1'b1);
    step("mchg", 1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step("mchg", 1'b1, W'($urandom), 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) step("mchg", 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) step("mchg", 1'b1, W'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step("mchg", 1'b0, '0, 1'b1, 1'b0);
    async_reset();

    // Random traffic with occasional async resets
    rmode = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) rmode = ~rmode;
      vec = W'($urandom);
      step("rand", $urandom_range(0, 2) != 0, vec, $urandom_range(0, 2) != 0, rmode);
      if ($urandom_range(0, 59) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l0_skew_buffer.md
# l0_skew_buffer

Parametrised L0 input buffer: `row` independent circular FIFOs of depth `depth`, written in parallel with one activation vector per cycle and drained toward the systolic array either all rows at once or in a diagonal (one-row-per-cycle) stagger. It is the next generation of the per-row input buffer in front of the MAC array. Over the earlier buffer it adds:
- generalised width, depth and row count;
- a run-time read mode;
- per-row output valids;
- a graceful stagger drain, so every row pops the same number of entries;
- overflow detection.

## Interface
Parameters:
- `row`, 8, number of rows (lanes); ≥2
- `bw`, 4, bits per row element
- `depth`, 64, entries per row FIFO; power of two, ≥2

Ports:
- `clk` in 1: single clock, all logic on posedge
- `reset` in 1: asynchronous, active-high
- `wr` in 1: push `in` into all rows
- `in` in row*bw: row i at bits [(i+1)*bw-1 : i*bw]
- `rd` in 1: read request (level)
- `mode` in 1: 0 = parallel read, 1 = staggered read
- `out` out row*bw: registered head data, same row packing as `in`
- `o_valid` out row: per-row "out slice updated this cycle"
- `o_full` out 1: any row full
- `o_ready` out 1: no row full (~o_full)
- `o_empty` out 1: all rows empty
- `o_ovf` out 1: sticky, set when `wr` is seen while `o_full`

## Operation
- Each row keeps a write pointer, a read pointer (wrap modulo `depth`) and a count of clog2(depth)+1 bits.
- Row full when count == depth; empty when count == 0.
- **Write:** `wr && o_ready` writes `in` to every row.
  - `wr && o_full`: nothing written in any row (no partial vectors); `o_ovf` set.
- **Read enables:** register `rd_en[row-1:0]`, reset 0.
  - mode 0: `rd_en <= {row{rd}}`.
  - mode 1: `rd_en <= {rd_en[row-2:0], rd}`. Deasserting `rd` shifts zeros in, so the stagger drains row by row and each row receives the same enable count.
- **Pop:** row i pops when `rd_en[i] && !empty[i]`.
  - On pop, that row's `out` slice is loaded with the head entry and `o_valid[i]`=1.
  - Otherwise the `out` slice holds and `o_valid[i]`=0.
- **Mode latch:** `mode` is latched only on cycles where `rd_en==0`. A change while enables are in flight is ignored until they drain.
- **Simultaneous push and pop on a row:** both take effect; count unchanged; pop returns the old head.
- **Empty rows:** a pop request on an empty row is dropped silently. There is no retry.

## Timing
- Reset values: `out`=0, `o_valid`=0, `o_ovf`=0, `o_empty`=1, `o_full`=0, `o_ready`=1; pointers, counts, `rd_en` and latched mode = 0.
- Reset mid-operation clears all contents immediately (async). The first legal write is the first posedge after `reset` falls.
- Write to read: data written at edge k can be popped at edge k+1 at the earliest (requires `rd_en[i]` set by `rd` sampled at edge k).
- Read latency, `rd` sampled high at edge k:
  - mode 0: all rows valid after edge k+1.
  - mode 1: row i valid after edge k+1+i.
- Stagger drain, mode 1: after `rd` falls (last sampled high at edge m), row i's enable is last set at edge m+i. Row i's last pop is at edge m+1+i.
- Flag timing: `o_full`/`o_empty`/`o_ready` are combinational from registered counts and reflect state after the last edge. `o_ovf` rises the edge after the offending `wr`.

## Structure
- Package `l0_pkg`: `L0_MODE_PAR`=1'b0, `L0_MODE_SKEW`=1'b1 constants; a clog2 helper function for pointer and count widths.
- Sub-module `l0_row_fifo` (bw, depth):
  - single-row circular buffer with pointers, count, registered out and valid;
  - ports: `clk`, `reset`, `wr`, `rd`, `in`, `out`, `o_valid`, `o_full`, `o_empty`.
- Top level instantiates `row` copies via generate and holds `rd_en`, the mode latch, flag reductions and `o_ovf`.

## Test plan
- **Reset / idle:** assert `reset` asynchronously mid-cycle → all outputs at reset values before the next edge; `o_empty`=1, `o_ready`=1.
- **Parallel read:** row=8, bw=4. Write vectors 0x76543210 then 0xFEDCBA98, then hold `rd` for 2 cycles in mode 0 → `o_valid`=0xFF on two consecutive cycles; `out`=0x76543210 then 0xFEDCBA98.
- **Staggered fill and drain:** write 3 vectors; pulse `rd` for 3 cycles in mode 1.
  - `o_valid` sequence: 0x01, 0x03, 0x07, 0x0E, 0x1C, 0x38, 0x70, 0xE0, 0xC0, 0x80.
  - Each row emits exactly 3 entries in write order; `o_empty`=1 afterwards.
- **Full / overflow:** depth=4. Write 4 vectors → `o_full`=1, `o_ready`=0. A fifth `wr` → contents unchanged, `o_ovf`=1 and sticky. A simultaneous `wr`+`rd` pop at full is not accepted for the write.
- **Wrap-around plus concurrent push/pop:** depth=4. Stream 10 vectors with `wr` and `rd` overlapping in mode 0 → output order matches input order across pointer wrap; count never exceeds 4.
- **Mode change in flight:** switch `mode` from 1 to 0 while `rd_en`≠0 → stagger completes unchanged; the new mode takes effect only after `rd_en` returns to 0.
